gpio_irq_ctrl: RTL and testbench
================================

// Module: gpio_irq_ctrl
// PURPOSE
//   Edge-event interrupt controller for the GPIO block. Samples gpio_input_val, detects per-pin
//   rising/falling edges, latches them in a pending register. Round-robin scheduler serialises
//   pending events into a valid/ready stream of pin IDs for the CPU-side AXI register slave.
// PARAMETERS
//   GPIO_PORT_NUM  32  number of pins; must match the GPIO block instance
//   SYNC_STAGES    2   input synchroniser depth, >=2
//   ID_W           5   width of irq_id, = $clog2(GPIO_PORT_NUM)
// PORTS
//   sys_clk         in   1    single clock for all logic
//   sys_rst         in   1    synchronous reset, active-high
//   gpio_input_val  in   N    pin levels from the GPIO block, asynchronous to sys_clk
//   cfg_en          in   N    1 = edge detection enabled for the pin
//   cfg_rise        in   N    1 = rising edge sets pending
//   cfg_fall        in   N    1 = falling edge sets pending (rise&fall = both edges)
//   clr_valid       in   1    qualifies clr_mask for one cycle
//   clr_mask        in   N    write-1-to-clear mask for pending
//   pending         out  N    pending status, readable by software
//   irq             out  1    level interrupt = |pending
//   irq_valid       out  1    irq_id holds a pending pin
//   irq_id          out  ID_W index of the presented pin
//   irq_ready       in   1    consumer accepts irq_id
// BEHAVIOUR
//   Reset: all sync flops, prev, pending, irq, irq_valid, irq_id, rr_ptr = 0. State = WARM.
//   Synchroniser: SYNC_STAGES flops per pin; cur = last stage; prev = cur delayed 1 cycle.
//   event[i] = cfg_en[i] & ((cfg_rise[i] & cur & ~prev) | (cfg_fall[i] & ~cur & prev)).
//   Warm-up: counter holds events at 0 for SYNC_STAGES+1 cycles after sys_rst deasserts.
//     A pin high out of reset produces no spurious rising event.
//   Pending update per bit, per cycle:
//     set on event; clear on clr_valid&clr_mask, or on accept of that id.
//     Set wins over either clear in the same cycle.
//   Disabling cfg_en does not clear pending. cfg_* changes take effect next cycle.
//   Latency: pin change at cycle 0 -> pending set, visible at cycle SYNC_STAGES+1 (3 by default).
//     irq_valid follows 1 cycle later.
//   FSM, 3 states:
//     WARM    -> IDLE when the warm-up counter expires.
//     IDLE    if pending != 0: pick the first set bit at index >= rr_ptr, wrapping past N-1 to 0.
//             Register the result in irq_id, assert irq_valid, go to PRESENT.
//     PRESENT irq_valid and irq_id stay stable until irq_valid & irq_ready (accept).
//             On accept: clear pending[irq_id]; rr_ptr = irq_id+1, wrapping N-1 -> 0;
//             deassert irq_valid; return to IDLE. One bubble cycle between grants.
//   Software W1C of the presented bit while in PRESENT clears pending, but the
//     presentation is not withdrawn. The later accept has no further effect.
//   A re-event on the presented pin in the accept cycle leaves the bit pending (set wins).
//   sys_rst in any state returns to WARM with all registers at their reset values.
//     In-flight presentation and pending events are lost.
//   irq_ready while irq_valid=0 is ignored.
// STRUCTURE
//   gpio_pkg: GPIO_PORT_NUM default, ID_W, FSM state encoding (WARM/IDLE/PRESENT).
//   Sub-module gpio_rr_arbiter: combinational find-first-set-from-pointer with wrap.
//     Inputs: req[N], ptr[ID_W]. Outputs: gnt_id[ID_W], gnt_any.
//   Top holds the synchroniser, edge detect, pending, warm-up counter and FSM.
// TESTING
//   1. Reset with pin 3 held high, cfg_rise=all, cfg_en=all.
//      -> pending stays 0 after warm-up; no irq.
//   2. Pin 5 rises at cycle 0, rise enabled -> pending[5]=1 at cycle 3, irq_valid at cycle 4.
//      Then irq_id=5, ready=1 -> pending 0, rr_ptr=6.
//   3. Pins 2, 7, 30 pend together with rr_ptr=8 -> grants 30, 2, 7 in order.
//      irq_id is stable while ready=0 for 5 cycles.
//   4. Pin 9, cfg_fall only: rising edge -> no event; falling edge -> pending[9].
//      Both enabled -> each edge pends.
//   5. clr_valid with clr_mask[4]=1 in the same cycle as a new pin-4 event -> pending[4] stays 1.
//      W1C of the presented id -> pending clears, irq_valid held until ready.
//   6. sys_rst asserted in PRESENT with 3 bits pending -> all outputs 0.
//      No grant until warm-up completes.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared defaults, FSM encoding and helpers for the GPIO interrupt controller
package gpio_pkg;

    localparam int GPIO_PORT_NUM_DEF = 32;
    localparam int ID_W_DEF          = $clog2(GPIO_PORT_NUM_DEF);
    localparam int SYNC_STAGES_DEF   = 2;

    typedef enum logic [1:0] {
        ST_WARM    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESENT = 2'd2
    } gpio_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// rtl/gpio_rr_arbiter.sv - combinational find-first-set starting at a pointer, wrapping at N-1
module gpio_rr_arbiter
    import gpio_pkg::*;
#(
    parameter int N    = GPIO_PORT_NUM_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    int idx;

    // Scan from the farthest offset down so the nearest set bit at/after ptr wins.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_id  = ID_W'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO edge-event interrupt controller with round-robin pin-ID stream
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_PORT_NUM = GPIO_PORT_NUM_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int ID_W          = ID_W_DEF
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [GPIO_PORT_NUM-1:0] gpio_input_val,
    input  logic [GPIO_PORT_NUM-1:0] cfg_en,
    input  logic [GPIO_PORT_NUM-1:0] cfg_rise,
    input  logic [GPIO_PORT_NUM-1:0] cfg_fall,
    input  logic                     clr_valid,
    input  logic [GPIO_PORT_NUM-1:0] clr_mask,
    output logic [GPIO_PORT_NUM-1:0] pending,
    output logic                     irq,
    output logic                     irq_valid,
    output logic [ID_W-1:0]          irq_id,
    input  logic                     irq_ready
);

    localparam int N     = GPIO_PORT_NUM;
    localparam int CNT_W = $clog2(SYNC_STAGES + 1) + 1;

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     cur;
    logic [N-1:0]     prev_q;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     event_vec;
    logic [N-1:0]     clr_vec;
    gpio_state_e      state_q, state_d;
    logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             irq_valid_q, irq_valid_d;
    logic             accept;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;

    assign cur    = sync_q[SYNC_STAGES-1];
    assign accept = irq_valid_q & irq_ready;

    // Events are masked while warming up so a pin already high out of reset stays quiet.
    always_comb begin
        event_vec = '0;
        if (state_q != ST_WARM) begin
            event_vec = cfg_en & ((cfg_rise & cur & ~prev_q) | (cfg_fall & ~cur & prev_q));
        end
    end

    always_comb begin
        clr_vec = clr_valid ? clr_mask : '0;
        if (accept) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_vec) | event_vec;
    end

    gpio_rr_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) u_arb (
        .req     (pending_q),
        .ptr     (rr_ptr_q),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        irq_id_d    = irq_id_q;
        rr_ptr_d    = rr_ptr_q;
        irq_valid_d = irq_valid_q;
        case (state_q)
            ST_WARM: begin
                if (warm_cnt_q == CNT_W'(SYNC_STAGES)) begin
                    state_d = ST_IDLE;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (gnt_any) begin
                    irq_id_d    = gnt_id;
                    irq_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (accept) begin
                    irq_valid_d = 1'b0;
                    rr_ptr_d    = ID_W'(wrap_inc(int'(irq_id_q), N));
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_WARM;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q      <= '0;
            pending_q   <= '0;
            state_q     <= ST_WARM;
            warm_cnt_q  <= '0;
            irq_id_q    <= '0;
            rr_ptr_q    <= '0;
            irq_valid_q <= 1'b0;
        end else begin
            sync_q[0] <= gpio_input_val;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q      <= cur;
            pending_q   <= pending_d;
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            irq_id_q    <= irq_id_d;
            rr_ptr_q    <= rr_ptr_d;
            irq_valid_q <= irq_valid_d;
        end
    end

    assign pending   = pending_q;
    assign irq       = |pending_q;
    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - self-checking bench for gpio_irq_ctrl against a behavioural model
module tb_gpio_irq_ctrl;

    localparam int N  = 32;
    localparam int S  = 2;
    localparam int IW = 5;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [N-1:0]  gpio_input_val, cfg_en, cfg_rise, cfg_fall, clr_mask, pending;
    logic          clr_valid, irq, irq_valid, irq_ready;
    logic [IW-1:0] irq_id;

    always #5 sys_clk = ~sys_clk;

    gpio_irq_ctrl #(
        .GPIO_PORT_NUM (N),
        .SYNC_STAGES   (S),
        .ID_W          (IW)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .gpio_input_val (gpio_input_val),
        .cfg_en         (cfg_en),
        .cfg_rise       (cfg_rise),
        .cfg_fall       (cfg_fall),
        .clr_valid      (clr_valid),
        .clr_mask       (clr_mask),
        .pending        (pending),
        .irq            (irq),
        .irq_valid      (irq_valid),
        .irq_id         (irq_id),
        .irq_ready      (irq_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: pin history as a delay queue, pending as a plain bit set.
    logic [N-1:0] m_pend, m_cur, m_prev;
    logic [N-1:0] m_q[$];
    int           m_warm;
    bit           m_pres;
    int           m_id, m_ptr;

    task automatic model_reset();
        m_pend = '0; m_cur = '0; m_prev = '0;
        m_q.delete();
        repeat (S) m_q.push_back('0);
        m_warm = S + 1;
        m_pres = 0; m_id = 0; m_ptr = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] nxt;
        bit accept, rose, fell;
        if (sys_rst) begin
            model_reset();
            return;
        end
        nxt    = m_pend;
        accept = m_pres && irq_ready;
        for (int i = 0; i < N; i++) begin
            if (clr_valid && clr_mask[i]) nxt[i] = 1'b0;
        end
        if (accept) nxt[m_id] = 1'b0;
        if (m_warm == 0) begin
            for (int i = 0; i < N; i++) begin
                rose = m_cur[i] && !m_prev[i];
                fell = !m_cur[i] && m_prev[i];
                if (cfg_en[i] && ((rose && cfg_rise[i]) || (fell && cfg_fall[i]))) nxt[i] = 1'b1;
            end
        end
        if (m_warm > 0) begin
            m_warm--;
        end else if (accept) begin
            m_pres = 0;
            m_ptr  = (m_id + 1) % N;
        end else if (!m_pres && m_pend != 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_pend[(m_ptr + k) % N]) begin
                    m_id = (m_ptr + k) % N;
                    break;
                end
            end
            m_pres = 1;
        end
        m_pend = nxt;
        m_prev = m_cur;
        m_q.push_back(gpio_input_val);
        void'(m_q.pop_front());
        m_cur = m_q[0];
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_edge();
        #1;
        check("pending", pending, m_pend);
        check("irq", {31'd0, irq}, {31'd0, |m_pend});
        check("irq_valid", {31'd0, irq_valid}, {31'd0, m_pres});
        check("irq_id", {27'd0, irq_id}, m_id);
    endtask

    task automatic grant(input string tag, input int exp_id);
        int t;
        t = 0;
        while (!irq_valid && t < 20) begin
            cycle();
            t++;
        end
        check({tag, "_valid"}, {31'd0, irq_valid}, 32'd1);
        check({tag, "_id"}, {27'd0, irq_id}, exp_id);
        irq_ready = 1'b1;
        cycle();
        irq_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, irq_valid}, 32'd0);
    endtask

    initial begin
        sys_rst = 1'b1; gpio_input_val = '0; cfg_en = '1; cfg_rise = '1; cfg_fall = '0;
        clr_valid = 1'b0; clr_mask = '0; irq_ready = 1'b0;
        gpio_input_val[3] = 1'b1;
        model_reset();

        // Pin high out of reset must not pend
        repeat (2) cycle();
        check("s1_rst_pend", pending, 32'd0);
        sys_rst = 1'b0;
        repeat (8) cycle();
        check("s1_pend", pending, 32'd0);
        check("s1_irq", {31'd0, irq}, 32'd0);

        // Latency: pending at cycle 3, irq_valid at cycle 4
        gpio_input_val[5] = 1'b1;
        repeat (2) cycle();
        check("s2_pend_c2", {31'd0, pending[5]}, 32'd0);
        cycle();
        check("s2_pend_c3", {31'd0, pending[5]}, 32'd1);
        check("s2_valid_c3", {31'd0, irq_valid}, 32'd0);
        cycle();
        check("s2_valid_c4", {31'd0, irq_valid}, 32'd1);
        check("s2_id", {27'd0, irq_id}, 32'd5);
        irq_ready = 1'b1;
        cycle();
        irq_ready = 1'b0;
        check("s2_pend_clr", pending, 32'd0);

        // Round robin from rr_ptr=8
        gpio_input_val[7] = 1'b1;
        grant("s3_a", 7);
        gpio_input_val[7] = 1'b0;
        repeat (4) cycle();
        gpio_input_val[2] = 1'b1; gpio_input_val[7] = 1'b1; gpio_input_val[30] = 1'b1;
        repeat (3) cycle();
        check("s3_pend3", pending, 32'h4000_0084);
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("s3_hold_id", {27'd0, irq_id}, 32'd30);
            check("s3_hold_valid", {31'd0, irq_valid}, 32'd1);
        end
        grant("s3_g30", 30);
        grant("s3_g2", 2);
        grant("s3_g7", 7);

        // Fall-only, then both edges
        cfg_rise[9] = 1'b0; cfg_fall[9] = 1'b1;
        gpio_input_val[9] = 1'b1;
        repeat (5) cycle();
        check("s4_rise_ignored", {31'd0, pending[9]}, 32'd0);
        gpio_input_val[9] = 1'b0;
        repeat (3) cycle();
        check("s4_fall_pend", {31'd0, pending[9]}, 32'd1);
        grant("s4_f", 9);
        cfg_rise[9] = 1'b1;
        gpio_input_val[9] = 1'b1;
        grant("s4_both_r", 9);
        gpio_input_val[9] = 1'b0;
        grant("s4_both_f", 9);

        // Set beats W1C; W1C of the presented id keeps the presentation
        cfg_fall[4] = 1'b1;
        gpio_input_val[4] = 1'b1;
        repeat (4) cycle();
        check("s5_pres_id", {27'd0, irq_id}, 32'd4);
        gpio_input_val[4] = 1'b0;
        repeat (2) cycle();
        clr_valid = 1'b1; clr_mask = 32'h10;
        cycle();
        clr_valid = 1'b0;
        check("s5_set_wins", {31'd0, pending[4]}, 32'd1);
        clr_valid = 1'b1;
        cycle();
        clr_valid = 1'b0; clr_mask = '0;
        check("s5_w1c", {31'd0, pending[4]}, 32'd0);
        check("s5_still_valid", {31'd0, irq_valid}, 32'd1);
        irq_ready = 1'b1;
        cycle();
        irq_ready = 1'b0;
        check("s5_accept_drop", {31'd0, irq_valid}, 32'd0);

        // Reset during PRESENT with three pins pending
        cfg_fall = '1;
        gpio_input_val[2] = 1'b0; gpio_input_val[7] = 1'b0; gpio_input_val[30] = 1'b0;
        repeat (4) cycle();
        check("s6_pres", {31'd0, irq_valid}, 32'd1);
        sys_rst = 1'b1;
        cycle();
        check("s6_pend0", pending, 32'd0);
        check("s6_irq0", {31'd0, irq}, 32'd0);
        check("s6_valid0", {31'd0, irq_valid}, 32'd0);
        check("s6_id0", {27'd0, irq_id}, 32'd0);
        sys_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("s6_no_grant", {31'd0, irq_valid}, 32'd0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            gpio_input_val = gpio_input_val ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) begin
                cfg_en = $urandom; cfg_rise = $urandom; cfg_fall = $urandom;
            end
            clr_valid = ($urandom_range(0, 7) == 0);
            clr_mask  = $urandom & $urandom;
            irq_ready = ($urandom_range(0, 2) == 0);
            sys_rst   = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
